// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 size codes,
// response-register states and the bytes-per-access helper.
package mem_pkg;

    localparam logic [2:0] MEM_SZ_B  = 3'b000;
    localparam logic [2:0] MEM_SZ_H  = 3'b001;
    localparam logic [2:0] MEM_SZ_W  = 3'b010;
    localparam logic [2:0] MEM_SZ_D  = 3'b011;
    localparam logic [2:0] MEM_SZ_BU = 3'b100;
    localparam logic [2:0] MEM_SZ_HU = 3'b101;
    localparam logic [2:0] MEM_SZ_WU = 3'b110;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Returns 0 for the reserved encoding 111.
    function automatic logic [3:0] mem_size_bytes(input logic [2:0] size);
        logic [3:0] n;
        case (size)
            MEM_SZ_B, MEM_SZ_BU:  n = 4'd1;
            MEM_SZ_H, MEM_SZ_HU:  n = 4'd2;
            MEM_SZ_W, MEM_SZ_WU:  n = 4'd4;
            MEM_SZ_D:             n = 4'd8;
            default:              n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store-data shift, load-lane
// extraction with sign/zero extension, and misalign/illegal-size detection.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int W  = 32,
    parameter int LB = $clog2(W / 8)
) (
    input  logic [LB-1:0]  i_addr_lo,
    input  logic [2:0]     i_size,
    input  logic [W-1:0]   i_wdata,
    input  logic [W-1:0]   i_rword,
    output logic [W/8-1:0] o_be,
    output logic [W-1:0]   o_wdata,
    output logic [W-1:0]   o_rdata,
    output logic           o_misalign,
    output logic           o_illegal
);

    logic [3:0]   w_nbytes;
    logic [3:0]   w_lo4;
    logic [W-1:0] w_rshift;
    logic         w_sign;
    int           w_nbits;

    assign w_nbytes = mem_size_bytes(i_size);
    assign w_lo4    = 4'(i_addr_lo);

    // Doubleword and WU only exist on a 64-bit datapath.
    assign o_illegal = (i_size == 3'b111) ||
                       ((W == 32) && ((i_size == MEM_SZ_D) || (i_size == MEM_SZ_WU)));

    assign o_misalign = (w_nbytes != 4'd0) && ((w_lo4 & (w_nbytes - 4'd1)) != 4'd0);

    always_comb begin
        o_be = '0;
        for (int i = 0; i < W / 8; i++) begin
            o_be[i] = (i >= int'(w_lo4)) && (i < int'(w_lo4) + int'(w_nbytes));
        end
    end

    assign o_wdata  = i_wdata << {i_addr_lo, 3'b000};
    assign w_rshift = i_rword >> {i_addr_lo, 3'b000};

    always_comb begin
        w_nbits = 8 * int'(w_nbytes);
        w_sign  = 1'b0;
        o_rdata = w_rshift;
        if ((w_nbits > 0) && (w_nbits < W)) begin
            for (int i = 0; i < W; i++) begin
                if (i == w_nbits - 1) w_sign = w_rshift[i] & ~i_size[2];
            end
            for (int i = 0; i < W; i++) begin
                if (i >= w_nbits) o_rdata[i] = w_sign;
            end
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage data memory with valid/ready load/store front end and a one-deep
// registered response. Optional macro MEM_LSU_MISALIGN_CHECK_EN faults misaligned accesses.
//
// state     | meaning
// RSP_EMPTY | no response held; a request is always accepted
// RSP_FULL  | response presented on o_rsp_*; held until i_rsp_ready
module mem_lsu
    import mem_pkg::*;
#(
    parameter int W = 32,
    parameter int D = 8
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic         i_req_we,
    input  logic [D-1:0] i_req_addr,
    input  logic [2:0]   i_req_size,
    input  logic [W-1:0] i_req_wdata,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [W-1:0] o_rsp_rdata,
    output logic         o_rsp_fault
);

    localparam int LB    = $clog2(W / 8);
    localparam int DEPTH = 2 ** (D - LB);

    logic [W-1:0]    r_mem [DEPTH];
    rsp_state_e      r_state;
    rsp_state_e      w_state_nxt;
    logic [W-1:0]    r_rsp_rdata;
    logic            r_rsp_fault;

    logic            w_accept;
    logic            w_fault;
    logic            w_misalign;
    logic            w_illegal;
    logic [LB-1:0]   w_addr_lo;
    logic [D-LB-1:0] w_word_idx;
    logic [W/8-1:0]  w_be;
    logic [W-1:0]    w_wdata;
    logic [W-1:0]    w_rdata;

`ifdef MEM_LSU_MISALIGN_CHECK_EN
    assign w_addr_lo = i_req_addr[LB-1:0];
`else
    // Clearing offset bits below the access size makes every access aligned.
    logic [LB-1:0] w_size_mask;
    assign w_size_mask = LB'(mem_size_bytes(i_req_size) - 4'd1);
    assign w_addr_lo   = i_req_addr[LB-1:0] & ~w_size_mask;
`endif

    assign w_word_idx  = i_req_addr[D-1:LB];
    assign o_rsp_valid = (r_state == RSP_FULL);
    assign o_req_ready = !o_rsp_valid || i_rsp_ready;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_fault     = w_misalign || w_illegal;

    mem_lane_align #(.W(W), .LB(LB)) u_align (
        .i_addr_lo  (w_addr_lo),
        .i_size     (i_req_size),
        .i_wdata    (i_req_wdata),
        .i_rword    (r_mem[w_word_idx]),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= RSP_EMPTY;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RSP_EMPTY: if (w_accept) w_state_nxt = RSP_FULL;
            RSP_FULL:  if (!w_accept && i_rsp_ready) w_state_nxt = RSP_EMPTY;
            default:   w_state_nxt = RSP_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
        end else if (w_accept) begin
            r_rsp_rdata <= (i_req_we || w_fault) ? '0 : w_rdata;
            r_rsp_fault <= w_fault;
        end
    end

    // Array is not reset; writes are blocked while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && w_accept && i_req_we && !w_fault) begin
            for (int i = 0; i < W / 8; i++) begin
                if (w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu (W=32, D=8): byte-array reference model,
// directed scenarios followed by randomized traffic with random back-pressure.
module tb_mem_lsu;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [7:0]  i_req_addr;
    logic [2:0]  i_req_size;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_fault;

    always #5 i_clk = ~i_clk;

    mem_lsu #(.W(32), .D(8)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_size  (i_req_size),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_fault (o_rsp_fault)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  m [256];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          prev_acc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: memory as bytes, little-endian, access by byte count.
    task automatic model(input bit we, input logic [7:0] addr, input logic [2:0] size,
                         input logic [31:0] wd, output logic [31:0] rd, output logic f);
        int nb;
        int eff;
        logic [31:0] v;
        case (size)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            3'd2:       nb = 4;
            default:    nb = 0;
        endcase
        rd  = 32'h0;
        f   = 1'b0;
        eff = int'(addr);
        if (nb == 0) f = 1'b1;
        else if (eff % nb != 0) begin
`ifdef MEM_LSU_MISALIGN_CHECK_EN
            f = 1'b1;
`else
            eff = eff - (eff % nb);
`endif
        end
        if (!f) begin
            if (we) begin
                for (int i = 0; i < nb; i++) m[eff + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = m[eff + i];
                if (size < 3'd4 && nb < 4 && v[8*nb - 1]) begin
                    for (int b = 8 * nb; b < 32; b++) v[b] = 1'b1;
                end
                rd = v;
            end
        end
    endtask

    task automatic drive_cycle(input bit v, input bit we, input logic [7:0] a,
                               input logic [2:0] sz, input logic [31:0] wd, input bit rr,
                               input bit use_exp, input logic [31:0] xrd, input bit xf,
                               output bit acc);
        logic [31:0] rd;
        logic        f;
        exp_t        e;
        @(posedge i_clk);
        #2;
        i_req_valid = v;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_size  = sz;
        i_req_wdata = wd;
        i_rsp_ready = rr;
        #2;
        if (prev_acc) check("rsp_latency", {31'b0, o_rsp_valid}, 32'd1);
        acc = v && o_req_ready;
        prev_acc = acc;
        if (acc) begin
            model(we, a, sz, wd, rd, f);
            if (use_exp) begin
                rd = xrd;
                f  = xf;
            end
            e.rdata = rd;
            e.fault = f;
            q.push_back(e);
        end
    endtask

    task automatic issue(input bit we, input logic [7:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input bit use_exp,
                         input logic [31:0] xrd, input bit xf);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 8) begin
            drive_cycle(1'b1, we, a, sz, wd, 1'b1, use_exp, xrd, xf, acc);
            tries++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got no accept, expected accept within 8 cycles");
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 8'h0, 3'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, acc);
    endtask

    // Monitor: a response is consumed at the edge after valid && ready.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #3;
            if (i_reset_n && o_rsp_valid && i_rsp_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got valid response, expected none");
                end else begin
                    e = q.pop_front();
                    check("rsp_rdata", o_rsp_rdata, e.rdata);
                    check("rsp_fault", {31'b0, o_rsp_fault}, {31'b0, e.fault});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        logic [31:0] held;

        i_reset_n   = 1'b0;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = 8'h0;
        i_req_size  = 3'd0;
        i_req_wdata = 32'h0;
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) m[i] = 8'h0;

        repeat (3) @(posedge i_clk);
        #4;
        check("reset_valid", {31'b0, o_rsp_valid}, 32'd0);
        check("reset_rdata", o_rsp_rdata, 32'd0);
        check("reset_fault", {31'b0, o_rsp_fault}, 32'd0);
        check("reset_ready", {31'b0, o_req_ready}, 32'd1);
        i_reset_n = 1'b1;

        for (int w = 0; w < 64; w++) issue(1'b1, 8'(w * 4), 3'd2, $urandom, 1'b0, 32'h0, 1'b0);

        issue(1'b1, 8'h10, 3'd2, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 8'h10, 3'd2, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);

        issue(1'b1, 8'h13, 3'd0, 32'h00000080, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 8'h13, 3'd0, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
        issue(1'b0, 8'h13, 3'd4, 32'h0, 1'b1, 32'h00000080, 1'b0);
        issue(1'b0, 8'h10, 3'd2, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0);

        issue(1'b1, 8'h22, 3'd1, 32'h00008234, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 8'h22, 3'd1, 32'h0, 1'b1, 32'hFFFF8234, 1'b0);
        issue(1'b0, 8'h22, 3'd5, 32'h0, 1'b1, 32'h00008234, 1'b0);
        issue(1'b0, 8'h20, 3'd2, 32'h0, 1'b0, 32'h0, 1'b0);

`ifdef MEM_LSU_MISALIGN_CHECK_EN
        issue(1'b1, 8'h11, 3'd2, 32'h11111111, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 8'h10, 3'd2, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0);
        issue(1'b0, 8'h11, 3'd2, 32'h0, 1'b1, 32'h0, 1'b1);
`else
        issue(1'b0, 8'h11, 3'd2, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0);
        issue(1'b0, 8'h23, 3'd5, 32'h0, 1'b1, 32'h00008234, 1'b0);
`endif
        issue(1'b1, 8'h10, 3'd3, 32'h55555555, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 8'h10, 3'd3, 32'h0, 1'b1, 32'h0, 1'b1);
        issue(1'b0, 8'h10, 3'd2, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0);

        // Back-pressure: response held, next request stalled, then resumes.
        idle(2);
        drive_cycle(1'b1, 1'b0, 8'h10, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, acc);
        check("bp_first_accept", {31'b0, acc}, 32'd1);
        held = 32'h0;
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b1, 1'b0, 8'h20, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, acc);
            check("bp_no_accept", {31'b0, acc}, 32'd0);
            check("bp_valid", {31'b0, o_rsp_valid}, 32'd1);
            check("bp_ready", {31'b0, o_req_ready}, 32'd0);
            if (c == 0) held = o_rsp_rdata;
            else check("bp_rdata_stable", o_rsp_rdata, held);
        end
        drive_cycle(1'b1, 1'b0, 8'h20, 3'd2, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, acc);
        check("bp_release_accept", {31'b0, acc}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            drive_cycle(1'b1, 1'b0, 8'(8'h30 + 4 * c), 3'd2, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, acc);
            check("b2b_accept", {31'b0, acc}, 32'd1);
        end

        // Reset while a response is pending and a store is presented.
        idle(2);
        drive_cycle(1'b1, 1'b0, 8'h10, 3'd2, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, acc);
        @(posedge i_clk);
        #2;
        i_reset_n   = 1'b0;
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = 8'h10;
        i_req_size  = 3'd2;
        i_req_wdata = 32'hCAFEF00D;
        i_rsp_ready = 1'b0;
        #2;
        check("rst_pending_valid", {31'b0, o_rsp_valid}, 32'd1);
        @(posedge i_clk);
        #4;
        check("rst_valid", {31'b0, o_rsp_valid}, 32'd0);
        check("rst_rdata", o_rsp_rdata, 32'd0);
        q.delete();
        prev_acc    = 1'b0;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_reset_n   = 1'b1;
        issue(1'b0, 8'h10, 3'd2, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0);

        for (int c = 0; c < 800; c++) begin
            drive_cycle(($urandom % 4) != 0, $urandom % 2, 8'($urandom), 3'($urandom_range(0, 7)),
                        $urandom, ($urandom % 4) != 0, 1'b0, 32'h0, 1'b0, acc);
        end

        for (int c = 0; c < 10 && q.size() != 0; c++) idle(1);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised data memory with a load/store front end for the RISC-V core's MEM stage. It accepts one request per cycle over a valid/ready handshake and supports byte, halfword, word and (when W=64) doubleword accesses with per-byte write enables. Loads are sign- or zero-extended. It returns a registered response one cycle after acceptance and holds that response under back-pressure. Misaligned accesses can optionally be detected and reported as faults.

## Interface
- W, 32, data width in bits; legal values 32 or 64
- D, 8, byte-address width; depth = 2**(D − log2(W/8)) words; the whole address space is backed
- i_clk  in  1  clock; all logic on the rising edge
- i_reset_n  in  1  synchronous, active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  request can be accepted this cycle
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  D  byte address
- i_req_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- i_req_wdata  in  W  store data, right-justified
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer accepts the response
- o_rsp_rdata  out  W  load result, extended to W; 0 for stores and faults
- o_rsp_fault  out  1  access faulted; any store in it was suppressed

## Operation
- Response register has two states, EMPTY and FULL.
  - EMPTY → FULL on accept (i_req_valid && o_req_ready).
  - FULL → EMPTY on i_rsp_ready when no new request is accepted.
  - FULL → FULL on simultaneous accept and consume.
- o_req_ready = !o_rsp_valid || i_rsp_ready. This is combinational and gives full throughput.
- Store:
  - Byte lanes are selected by addr[log2(W/8)−1:0] and size.
  - wdata is shifted into those lanes; only the enabled bytes are written at the accept edge.
  - A store always produces a response, with rdata=0.
- Load:
  - The array is read at the accept edge.
  - The lane is extracted and extended: B/H/W signed; BU/HU/WU zero-extended.
  - D is the full word.
- Illegal size faults and suppresses the write. This holds in both builds. Illegal sizes are:
  - 011, 110 and 111 when W=32
  - 111 when W=64
- A load followed by a store to the same address on the next cycle returns the old data for the load, because the array read is registered.

## Timing
- Load/store latency is one cycle: accept at edge N gives o_rsp_valid=1 with data after edge N.
- While FULL and !i_rsp_ready, o_rsp_rdata and o_rsp_fault stay stable and no new request is accepted.
- Reset values: o_rsp_valid=0, o_rsp_rdata=0, o_rsp_fault=0. o_req_ready follows its equation.
- While i_reset_n=0:
  - No array write occurs, even if i_req_valid=1.
  - A pending response is discarded.
  - Array contents are not cleared.
- A response is never dropped or duplicated outside reset.

## Configuration
- MEM_LSU_MISALIGN_CHECK_EN defined:
  - The following accesses raise o_rsp_fault=1, return rdata=0 and write nothing:
    - H/HU with addr[0]≠0
    - W/WU with addr[1:0]≠0
    - D with addr[2:0]≠0
- Undefined:
  - Low address bits below the access size are forced to zero, so the access is naturally aligned.
  - Misalignment never faults; o_rsp_fault reflects only illegal size.

## Structure
- Package mem_pkg holds:
  - the size-encoding localparams MEM_SZ_B … MEM_SZ_WU
  - the helper function returning bytes-per-size
- Sub-module mem_lane_align is purely combinational. It performs:
  - byte-enable generation
  - write-data lane shift
  - read-lane extraction and sign/zero extension
  - misalign/illegal detection
- The top holds the array, the response register, the handshake and the macro-dependent address masking.

## Test plan
All scenarios use W=32 and D=8.
1. SW 0xDEADBEEF @0x10, then LW @0x10 → rsp one cycle after accept, rdata=0xDEADBEEF, fault=0.
2. SB 0x80 @0x13, then:
   - LB @0x13 → 0xFFFFFF80
   - LBU @0x13 → 0x00000080
   - LW @0x10 → 0x80ADBEEF
3. SH 0x8234 @0x22, then:
   - LH @0x22 → 0xFFFF8234
   - LHU @0x22 → 0x00008234
   - LW @0x20 → 0x8234xxxx, with the low half unchanged
4. LW with i_rsp_ready=0 for 3 cycles → o_rsp_valid=1, rdata stable, o_req_ready=0, next request held. When i_rsp_ready=1, the next request is accepted the same cycle and back-to-back throughput resumes.
5. Misaligned access:
   - With MEM_LSU_MISALIGN_CHECK_EN: SW 0x11111111 @0x11 → fault=1 and 0x10 unchanged; LW @0x11 → fault=1, rdata=0.
   - Without the macro: LW @0x11 returns the word at 0x10.
   - In both builds, size 011 → fault=1.
6. Reset mid-operation: drop i_reset_n while o_rsp_valid=1 and a SW is presented → after the edge o_rsp_valid=0 and the SW is not written. After reset, LW @0x10 still returns the pre-reset value.
